jtcps15_qsnd_vol: RTL

// - Output gain stage downstream of the CPS1.5 sound block. Consumes its left/right/sample stream.
// - Applies the 2 dB/step cabinet volume driven by the vol_up/vol_down buttons.
// - Emits saturated 16-bit stereo with a one-cycle strobe to the frame audio mixer.

---
 rtl/jtcps15_qsnd_vol.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/jtcps15_qsnd_vol.sv
// rtl/jtcps15_qsnd_vol.sv - CPS1.5 sound output gain stage with 2 dB/step cabinet volume
// Optional DC blocker ahead of the gain multiply is enabled by defining JTCPS15_DCBLOCK_EN.
module jtcps15_qsnd_vol #(
   parameter logic [4:0] VOL_INIT = 5'd15
`ifdef JTCPS15_DCBLOCK_EN
   ,
   parameter int         DCSHIFT  = 8
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vol_up,
   input  logic        vol_down,
   input  logic [15:0] left,
   input  logic [15:0] right,
   input  logic        sample,
   output logic [15:0] snd_left,
   output logic [15:0] snd_right,
   output logic        snd_sample,
   output logic [4:0]  vol_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DCB,
      S_MUL_L,
      S_MUL_R,
      S_OUT
   } state_t;

   localparam logic [4:0]         VOL_MAX = 5'd17;
   localparam logic signed [23:0] SAT_HI  = 24'sd32767;
   localparam logic signed [23:0] SAT_LO  = -24'sd32768;

   state_t      state_q;
   logic [4:0]  vol_q, vol_d;
   logic        up_q, dn_q;
   logic        up_rise, dn_rise;
   logic [15:0] in_l_q, in_r_q;
   logic [7:0]  gain_q;
   logic [15:0] res_l_q;
   logic [15:0] snd_left_q, snd_right_q;
   logic        snd_sample_q;

   logic [15:0]        ch_l, ch_r;
   logic [15:0]        mul_x;
   logic signed [23:0] mul_a, mul_b, prod, prod_sh;
   logic [15:0]        mul_out;

   function automatic logic [7:0] gain_of(input logic [4:0] idx);
      case (idx)
         5'd0:    gain_of = 8'd0;
         5'd1:    gain_of = 8'd5;
         5'd2:    gain_of = 8'd6;
         5'd3:    gain_of = 8'd8;
         5'd4:    gain_of = 8'd10;
         5'd5:    gain_of = 8'd13;
         5'd6:    gain_of = 8'd16;
         5'd7:    gain_of = 8'd20;
         5'd8:    gain_of = 8'd25;
         5'd9:    gain_of = 8'd32;
         5'd10:   gain_of = 8'd40;
         5'd11:   gain_of = 8'd51;
         5'd12:   gain_of = 8'd64;
         5'd13:   gain_of = 8'd81;
         5'd14:   gain_of = 8'd102;
         5'd15:   gain_of = 8'd128;
         5'd16:   gain_of = 8'd161;
         5'd17:   gain_of = 8'd203;
         default: gain_of = 8'd0;
      endcase
   endfunction

   function automatic logic [15:0] sat16(input logic signed [23:0] v);
      if (v > SAT_HI)
         sat16 = 16'h7FFF;
      else if (v < SAT_LO)
         sat16 = 16'h8000;
      else
         sat16 = v[15:0];
   endfunction

`ifdef JTCPS15_DCBLOCK_EN
   localparam logic signed [21:0] DC_HI = 22'sd524287;
   localparam logic signed [21:0] DC_LO = -22'sd524288;

   logic signed [19:0] x1_l_q, x1_r_q, y1_l_q, y1_r_q;
   logic signed [19:0] dcy_l_q, dcy_r_q;

   function automatic logic signed [19:0] dc_step(input logic [15:0] x,
                                                  input logic signed [19:0] x1,
                                                  input logic signed [19:0] y1);
      logic signed [19:0] ys;
      logic signed [21:0] t;
      ys = y1 >>> DCSHIFT;
      t  = {{6{x[15]}}, x} - {{2{x1[19]}}, x1} + {{2{y1[19]}}, y1} - {{2{ys[19]}}, ys};
      if (t > DC_HI)
         dc_step = 20'sh7FFFF;
      else if (t < DC_LO)
         dc_step = 20'sh80000;
      else
         dc_step = t[19:0];
   endfunction

   assign ch_l = sat16({{4{dcy_l_q[19]}}, dcy_l_q});
   assign ch_r = sat16({{4{dcy_r_q[19]}}, dcy_r_q});
`else
   assign ch_l = in_l_q;
   assign ch_r = in_r_q;
`endif

   // Only a rising edge counts; simultaneous presses cancel out.
   assign up_rise = vol_up & ~up_q;
   assign dn_rise = vol_down & ~dn_q;

   always_comb begin
      vol_d = vol_q;
      if (up_rise && !dn_rise && vol_q < VOL_MAX)
         vol_d = vol_q + 5'd1;
      else if (dn_rise && !up_rise && vol_q != 5'd0)
         vol_d = vol_q - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         up_q  <= 1'b0;
         dn_q  <= 1'b0;
         vol_q <= VOL_INIT;
      end else begin
         up_q  <= vol_up;
         dn_q  <= vol_down;
         vol_q <= vol_d;
      end
   end

   // One multiplier, time-shared between channels by the FSM state.
   always_comb begin
      mul_x   = (state_q == S_MUL_R) ? ch_r : ch_l;
      mul_a   = {{8{mul_x[15]}}, mul_x};
      mul_b   = {16'd0, gain_q};
      prod    = mul_a * mul_b;
      prod_sh = prod >>> 7;
      mul_out = sat16(prod_sh);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         in_l_q       <= 16'd0;
         in_r_q       <= 16'd0;
         gain_q       <= 8'd0;
         res_l_q      <= 16'd0;
         snd_left_q   <= 16'd0;
         snd_right_q  <= 16'd0;
         snd_sample_q <= 1'b0;
`ifdef JTCPS15_DCBLOCK_EN
         x1_l_q  <= 20'sd0;
         x1_r_q  <= 20'sd0;
         y1_l_q  <= 20'sd0;
         y1_r_q  <= 20'sd0;
         dcy_l_q <= 20'sd0;
         dcy_r_q <= 20'sd0;
`endif
      end else begin
         snd_sample_q <= 1'b0;
         if (sample) begin
            // A new sample always restarts the pipeline; gain is frozen here for both channels.
            in_l_q <= left;
            in_r_q <= right;
            gain_q <= gain_of(vol_q);
`ifdef JTCPS15_DCBLOCK_EN
            state_q <= S_DCB;
`else
            state_q <= S_MUL_L;
`endif
         end else begin
            case (state_q)
`ifdef JTCPS15_DCBLOCK_EN
               S_DCB: begin
                  dcy_l_q <= dc_step(in_l_q, x1_l_q, y1_l_q);
                  dcy_r_q <= dc_step(in_r_q, x1_r_q, y1_r_q);
                  state_q <= S_MUL_L;
               end
`endif
               S_MUL_L: begin
                  res_l_q <= mul_out;
                  state_q <= S_MUL_R;
               end
               S_MUL_R: begin
                  snd_left_q   <= res_l_q;
                  snd_right_q  <= mul_out;
                  snd_sample_q <= 1'b1;
                  state_q      <= S_OUT;
`ifdef JTCPS15_DCBLOCK_EN
                  x1_l_q <= {{4{in_l_q[15]}}, in_l_q};
                  x1_r_q <= {{4{in_r_q[15]}}, in_r_q};
                  y1_l_q <= dcy_l_q;
                  y1_r_q <= dcy_r_q;
`endif
               end
               S_OUT:   state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign snd_left   = snd_left_q;
   assign snd_right  = snd_right_q;
   assign snd_sample = snd_sample_q;
   assign vol_idx    = vol_q;

endmodule
